pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage CPU. It drives the enables and flushes of PC, IF_ID, ID_EX and EX_MEM.
//  MEM_WB has no enable, so the block kills writeback by gating RegWrite_in/MemtoReg_in into MEM_WB.
//  It handles load-use hazards, taken-branch flushes and a multi-cycle data-memory handshake with a timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and data-memory wait handling.
// Optional stall-cycle counter is built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wn,
  input  logic             ex_branch_tk,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_kill,
  output logic             dmem_req,
  output logic             dmem_abort,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_nextWcnt;
  logic              r_memErr;
  logic              w_timeout;
  logic              w_memStall;
  logic              w_loadUse;

  // Once waiting, the access is owned by MEM_WAIT until ready or timeout.
  assign w_timeout  = (r_state == MEM_WAIT) && !dmem_ready &&
                      (r_wcnt == WCNT_W'(MEM_TIMEOUT - 1));
  assign w_memStall = (r_state == MEM_WAIT) ? (!dmem_ready && !w_timeout)
                                            : (mem_req && !dmem_ready);
  assign w_loadUse  = ex_memread && (ex_wn != 5'd0) &&
                      ((ex_wn == id_rs) || (ex_wn == id_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_wcnt   <= '0;
      r_memErr <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_wcnt  <= w_nextWcnt;
      if (w_timeout) r_memErr <= 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextWcnt  = r_wcnt;
    case (r_state)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          w_nextState = MEM_WAIT;
          w_nextWcnt  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || w_timeout) begin
          w_nextState = RUN;
          w_nextWcnt  = '0;
        end else begin
          w_nextWcnt = r_wcnt + WCNT_W'(1);
        end
      end
      default: begin
        w_nextState = RUN;
        w_nextWcnt  = '0;
      end
    endcase
  end

  // Priority: reset, timeout, memory stall, taken branch, load-use, free run.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_kill = 1'b0;
    dmem_req   = mem_req;
    dmem_abort = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_en    = 1'b0;
      idex_flush = 1'b1;
      exmem_en   = 1'b0;
      memwb_kill = 1'b1;
      dmem_req   = 1'b0;
    end else if (w_timeout) begin
      memwb_kill = 1'b1;
      dmem_req   = 1'b0;
      dmem_abort = 1'b1;
    end else if (w_memStall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_kill = 1'b1;
      dmem_req   = 1'b1;
    end else if (ex_branch_tk) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_loadUse) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign mem_err = r_memErr;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCycles <= '0;
    end else if (!pc_en && (r_stallCycles != {CNT_W{1'b1}})) begin
      r_stallCycles <= r_stallCycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stallCycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level model of the hazard priorities and memory wait timeout.
module tb_pipeline_hazard_ctrl;

  localparam int TO    = 16;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_memread;
  logic [4:0]       ex_wn;
  logic             ex_branch_tk;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_kill;
  logic             dmem_req;
  logic             dmem_abort;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int passes = 0;

  // Model state: are we waiting on memory, how long, sticky error, stall count
  bit     mWait     = 0;
  int     mWaitCnt  = 0;
  bit     mErr      = 0;
  longint mStall    = 0;

  logic [8:0] expV;
  logic [8:0] obsV;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_wn(ex_wn), .ex_branch_tk(ex_branch_tk),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_kill(memwb_kill), .dmem_req(dmem_req), .dmem_abort(dmem_abort),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_kill dmem_req dmem_abort
  function automatic logic [8:0] outVec();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_kill, dmem_req, dmem_abort};
  endfunction

  function automatic logic [8:0] modelExpect();
    bit hazard;
    hazard = ex_memread && (ex_wn != 0) && (ex_wn == id_rs || ex_wn == id_rt);
    if (rst)                                        return 9'b001010100;
    if (mWait && !dmem_ready && mWaitCnt == TO - 1) return 9'b110101101;
    if (mWait ? !dmem_ready : (mem_req && !dmem_ready)) return 9'b000000110;
    if (ex_branch_tk)                               return {7'b1111110, mem_req, 1'b0};
    if (hazard)                                     return {7'b0001110, mem_req, 1'b0};
    return {7'b1101010, mem_req, 1'b0};
  endfunction

  task automatic modelTick(input logic [8:0] e);
    if (rst) begin
      mWait = 0; mWaitCnt = 0; mErr = 0; mStall = 0;
    end else begin
`ifdef PIPE_PERF_CNT_EN
      if (!e[8] && mStall < 64'hFFFFFFFF) mStall++;
`endif
      if (mWait) begin
        if (dmem_ready) mWait = 0;
        else if (mWaitCnt == TO - 1) begin mWait = 0; mErr = 1; end
        else mWaitCnt++;
      end else if (mem_req && !dmem_ready) begin
        mWait = 1; mWaitCnt = 1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic mr, input logic rdy, input logic ld,
                       input logic [4:0] wn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic bt);
    rst = r; mem_req = mr; dmem_ready = rdy; ex_memread = ld;
    ex_wn = wn; id_rs = rs; id_rt = rt; ex_branch_tk = bt;
  endtask

  task automatic sample();
    @(negedge clk);
    expV = modelExpect();
    obsV = outVec();
  endtask

  task automatic advance();
    @(posedge clk);
    modelTick(expV);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      sample();
      checks++;
      if (obsV !== 9'b001010100) $display("[TB] FAIL reset_vec: got %b expected %b", obsV, 9'b001010100);
      else passes++;
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checks++;
    if (obsV !== 9'b110101000) $display("[TB] FAIL release_vec: got %b expected %b", obsV, 9'b110101000);
    else passes++;
    checks++;
    if (mem_err !== 1'b0 || stall_cycles !== '0)
      $display("[TB] FAIL reset_regs: got mem_err=%b stall=%0d expected 0/0", mem_err, stall_cycles);
    else passes++;
    advance();
  endtask

  task automatic test_load_use();
    drive(0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 0);
    sample();
    checks++;
    if (obsV !== 9'b000111000) $display("[TB] FAIL load_use: got %b expected %b", obsV, 9'b000111000);
    else passes++;
    advance();
    drive(0, 0, 0, 0, 5'd3, 5'd3, 5'd8, 0);
    sample();
    checks++;
    if (obsV !== 9'b110101000) $display("[TB] FAIL load_use_after: got %b expected %b", obsV, 9'b110101000);
    else passes++;
    advance();
    drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    sample();
    checks++;
    if (obsV !== 9'b110101000) $display("[TB] FAIL load_use_r0: got %b expected %b", obsV, 9'b110101000);
    else passes++;
    advance();
  endtask

  task automatic test_branch_priority();
    drive(0, 0, 0, 1, 5'd9, 5'd9, 5'd2, 1);
    sample();
    checks++;
    if (obsV !== 9'b111111000) $display("[TB] FAIL branch_over_load: got %b expected %b", obsV, 9'b111111000);
    else passes++;
    advance();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      sample();
      checks++;
      if (obsV !== 9'b000000110) $display("[TB] FAIL mem_wait_stall%0d: got %b expected %b", i, obsV, 9'b000000110);
      else passes++;
      advance();
    end
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    sample();
    checks++;
    if (obsV !== 9'b110101010) $display("[TB] FAIL mem_wait_done: got %b expected %b", obsV, 9'b110101010);
    else passes++;
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checks++;
    if (obsV !== 9'b110101000) $display("[TB] FAIL mem_wait_run: got %b expected %b", obsV, 9'b110101000);
    else passes++;
    checks++;
    if (stall_cycles !== CNT_W'(mStall)) $display("[TB] FAIL stall_count: got %0d expected %0d", stall_cycles, mStall);
    else passes++;
    advance();
  endtask

  task automatic test_timeout();
    for (int c = 1; c <= TO; c++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      sample();
      checks++;
      if (c < TO && obsV !== 9'b000000110)
        $display("[TB] FAIL timeout_wait%0d: got %b expected %b", c, obsV, 9'b000000110);
      else if (c == TO && obsV !== 9'b110101101)
        $display("[TB] FAIL timeout_abort: got %b expected %b", obsV, 9'b110101101);
      else passes++;
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      checks++;
      if (mem_err !== 1'b1 || obsV !== 9'b110101000)
        $display("[TB] FAIL timeout_sticky: got err=%b vec=%b expected err=1 vec=%b", mem_err, obsV, 9'b110101000);
      else passes++;
      advance();
    end
  endtask

  task automatic test_reset_in_wait();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample();
    advance();
    for (int c = 1; c <= 5; c++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      sample();
      checks++;
      if (obsV !== 9'b000000110) $display("[TB] FAIL rstwait_stall%0d: got %b expected %b", c, obsV, 9'b000000110);
      else passes++;
      advance();
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    sample();
    checks++;
    if (obsV !== 9'b001010100) $display("[TB] FAIL rstwait_vec: got %b expected %b", obsV, 9'b001010100);
    else passes++;
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      checks++;
      if (mem_err !== 1'b0 || obsV !== 9'b110101000)
        $display("[TB] FAIL rstwait_after: got err=%b vec=%b expected err=0 vec=%b", mem_err, obsV, 9'b110101000);
      else passes++;
      advance();
    end
  endtask

  task automatic test_random();
    int readyBias;
    readyBias = 5;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) readyBias = $urandom_range(0, 9);
      drive(($urandom_range(0, 59) == 0),
            mWait ? 1'b1 : ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) < readyBias),
            ($urandom_range(0, 1) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0));
      sample();
      checks++;
      if (obsV !== expV || mem_err !== mErr || stall_cycles !== CNT_W'(mStall))
        $display("[TB] FAIL random%0d: got vec=%b err=%b stall=%0d expected vec=%b err=%b stall=%0d",
                 i, obsV, mem_err, stall_cycles, expV, mErr, mStall);
      else passes++;
      advance();
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
